// File: rtl/divmmc_ctrl.sv
// divMMC control stage: decodes Z80 I/O writes and opcode fetches into the paging
// controls for 0000-3FFF, and runs the mode-0 SPI port to the SD card.
module divmmc_ctrl #(
    parameter int SPI_DIV  = 1,
    parameter bit NMI_TRAP = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        mreq_i,
    input  logic        iorq_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        m1_i,
    input  logic [15:0] a_i,
    input  logic [7:0]  di_i,
    output logic [7:0]  do_o,
    output logic        ioe_o,
    output logic        div_map_o,
    output logic        div_ram_o,
    output logic [3:0]  div_page_o,
    output logic        spi_cs_o,
    output logic        spi_ck_o,
    output logic        spi_do_o,
    input  logic        spi_di_i
);

    localparam int CW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [CW-1:0] DIV_LOAD = CW'(SPI_DIV - 1);

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_MAP   = 2'd1,
        PEND_UNMAP = 2'd2
    } pend_t;

    logic          io_wr_q, io_rd_q, fetch_q;
    logic          conmem_q, mapram_q, automap_q, cs_q;
    logic [3:0]    page_q;
    pend_t         pend_q, pend_d;
    logic          automap_d;

    logic          busy_q, sck_q;
    logic [CW-1:0] div_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    tx_q, shift_q, rx_q;

    logic io_wr, io_rd, fetch;
    logic wr_stb, rd_stb, fetch_stb;
    logic port_e3, port_e7, port_eb;
    logic trap_hit, automap_hit, unmap_hit;
    logic spi_start;

    assign io_wr     = !iorq_i && !wr_i;
    assign io_rd     = !iorq_i && !rd_i;
    assign fetch     = !m1_i && !mreq_i;
    assign wr_stb    = io_wr && !io_wr_q;
    assign rd_stb    = io_rd && !io_rd_q;
    assign fetch_stb = fetch && !fetch_q;

    assign port_e3 = (a_i[7:0] == 8'hE3);
    assign port_e7 = (a_i[7:0] == 8'hE7);
    assign port_eb = (a_i[7:0] == 8'hEB);

    assign trap_hit = (a_i == 16'h0000) || (a_i == 16'h0008) || (a_i == 16'h0038) ||
                      (a_i == 16'h04C6) || (a_i == 16'h0562) ||
                      (NMI_TRAP && (a_i == 16'h0066));
    assign automap_hit = (a_i[15:8] == 8'h3D);
    assign unmap_hit   = (a_i[15:3] == 13'h03FF);

    assign spi_start = !busy_q && port_eb && (wr_stb || rd_stb);

    // 3D00-3DFF maps at once and drops any pending request, so a stale UNMAP cannot undo it.
    always_comb begin
        automap_d = automap_q;
        pend_d    = pend_q;
        if (fetch_stb) begin
            if (automap_hit) begin
                automap_d = 1'b1;
                pend_d    = PEND_NONE;
            end else if (trap_hit) begin
                pend_d = PEND_MAP;
            end else if (unmap_hit) begin
                pend_d = PEND_UNMAP;
            end
        end else if (m1_i && (pend_q != PEND_NONE)) begin
            automap_d = (pend_q == PEND_MAP);
            pend_d    = PEND_NONE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            io_wr_q   <= 1'b0;
            io_rd_q   <= 1'b0;
            fetch_q   <= 1'b0;
            conmem_q  <= 1'b0;
            mapram_q  <= 1'b0;
            page_q    <= 4'd0;
            cs_q      <= 1'b1;
            automap_q <= 1'b0;
            pend_q    <= PEND_NONE;
        end else begin
            io_wr_q   <= io_wr;
            io_rd_q   <= io_rd;
            fetch_q   <= fetch;
            automap_q <= automap_d;
            pend_q    <= pend_d;
            if (wr_stb && port_e3) begin
                conmem_q <= di_i[7];
                mapram_q <= mapram_q | di_i[6];
                page_q   <= di_i[3:0];
            end
            if (wr_stb && port_e7) begin
                cs_q <= di_i[0];
            end
        end
    end

    // Rising SCK samples MISO, falling SCK shifts MOSI; the 8th fall ends the byte.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'hFF;
            shift_q   <= 8'hFF;
            rx_q      <= 8'hFF;
        end else if (spi_start) begin
            busy_q    <= 1'b1;
            sck_q     <= 1'b0;
            div_cnt_q <= DIV_LOAD;
            bit_cnt_q <= 3'd0;
            tx_q      <= wr_stb ? di_i : 8'hFF;
        end else if (busy_q) begin
            if (div_cnt_q == '0) begin
                div_cnt_q <= DIV_LOAD;
                sck_q     <= !sck_q;
                if (!sck_q) begin
                    shift_q <= {shift_q[6:0], spi_di_i};
                end else begin
                    tx_q      <= {tx_q[6:0], 1'b1};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        busy_q <= 1'b0;
                        rx_q   <= shift_q;
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q - 1'b1;
            end
        end
    end

    assign do_o       = rx_q;
    assign ioe_o      = io_rd && port_eb;
    assign div_map_o  = conmem_q || automap_q;
    assign div_ram_o  = mapram_q && !conmem_q;
    assign div_page_o = page_q;
    assign spi_cs_o   = cs_q;
    assign spi_ck_o   = sck_q;
    assign spi_do_o   = tx_q[7];

endmodule

// File: tb/tb_divmmc_ctrl.sv
// Directed bench for divmmc_ctrl: one instance with NMI trap and SPI_DIV=1, a second
// with no NMI trap and SPI_DIV=2, both with MISO looped back to MOSI.
module tb_divmmc_ctrl;

    logic        clk = 1'b0;
    logic        rst, mreq, iorq, rd, wr, m1;
    logic [15:0] a;
    logic [7:0]  di;

    logic [7:0]  do1, do2;
    logic        ioe1, ioe2, map1, map2, ram1, ram2;
    logic [3:0]  page1, page2;
    logic        cs1, cs2, ck1, ck2, mo1, mo2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divmmc_ctrl #(.SPI_DIV(1), .NMI_TRAP(1'b1)) dut (
        .clock_i(clk), .reset_i(rst), .mreq_i(mreq), .iorq_i(iorq), .rd_i(rd), .wr_i(wr),
        .m1_i(m1), .a_i(a), .di_i(di), .do_o(do1), .ioe_o(ioe1), .div_map_o(map1),
        .div_ram_o(ram1), .div_page_o(page1), .spi_cs_o(cs1), .spi_ck_o(ck1),
        .spi_do_o(mo1), .spi_di_i(mo1)
    );

    divmmc_ctrl #(.SPI_DIV(2), .NMI_TRAP(1'b0)) dut2 (
        .clock_i(clk), .reset_i(rst), .mreq_i(mreq), .iorq_i(iorq), .rd_i(rd), .wr_i(wr),
        .m1_i(m1), .a_i(a), .di_i(di), .do_o(do2), .ioe_o(ioe2), .div_map_o(map2),
        .div_ram_o(ram2), .div_page_o(page2), .spi_cs_o(cs2), .spi_ck_o(ck2),
        .spi_do_o(mo2), .spi_di_i(mo2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        a = addr; di = data; iorq = 1'b0; wr = 1'b0;
        step();
        iorq = 1'b1; wr = 1'b1;
        step();
    endtask

    task automatic fetch_begin(input logic [15:0] addr);
        a = addr; m1 = 1'b0; mreq = 1'b0;
    endtask

    task automatic fetch_end();
        m1 = 1'b1; mreq = 1'b1;
    endtask

    logic [7:0] exp_byte;

    initial begin
        rst = 1'b1; mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1;
        a = 16'h0000; di = 8'h00;
        step(); step();
        rst = 1'b0;

        chk("rst_map", 16'(map1), 16'h0);
        chk("rst_ram", 16'(ram1), 16'h0);
        chk("rst_page", 16'(page1), 16'h0);
        chk("rst_cs", 16'(cs1), 16'h1);
        chk("rst_ck", 16'(ck1), 16'h0);
        chk("rst_mosi", 16'(mo1), 16'h1);
        chk("rst_do", 16'(do1), 16'h00FF);
        chk("rst_ioe", 16'(ioe1), 16'h0);

        // Deferred map on 0038
        fetch_begin(16'h0038);
        step(); step(); step();
        chk("t1_during", 16'(map1), 16'h0);
        fetch_end();
        chk("t1_m1_high_preclk", 16'(map1), 16'h0);
        step();
        chk("t1_after", 16'(map1), 16'h1);
        chk("t1_after_n0", 16'(map2), 16'h1);

        // Deferred unmap on 1FFA, instant map on 3D2F
        fetch_begin(16'h1FFA);
        step(); step(); step();
        chk("t2_unmap_during", 16'(map1), 16'h1);
        fetch_end();
        step();
        chk("t2_unmap_after", 16'(map1), 16'h0);
        fetch_begin(16'h3D2F);
        step();
        chk("t2_3d_instant", 16'(map1), 16'h1);
        fetch_end();
        step();
        chk("t2_3d_held", 16'(map1), 16'h1);

        // Unmap to clear, then 1FF8 pending followed by 3D00 in the same M1
        fetch_begin(16'h1FFC); step(); fetch_end(); step();
        chk("t2_clear", 16'(map1), 16'h0);
        fetch_begin(16'h1FF8);
        step();
        mreq = 1'b1;
        step();
        a = 16'h3D00; mreq = 1'b0;
        step();
        chk("t2_stale_map", 16'(map1), 16'h1);
        fetch_end();
        step(); step();
        chk("t2_stale_kept", 16'(map1), 16'h1);
        chk("t2_stale_kept_n0", 16'(map2), 16'h1);

        // NMI trap at 0066 and an unrelated address
        fetch_begin(16'h1FFC); step(); fetch_end(); step();
        chk("t6_clear", 16'(map1), 16'h0);
        fetch_begin(16'h0100); step(); fetch_end(); step();
        chk("t6_other", 16'(map1), 16'h0);
        fetch_begin(16'h0066); step(); step(); fetch_end();
        chk("t6_nmi_preclk", 16'(map1), 16'h0);
        step();
        chk("t6_nmi_trap1", 16'(map1), 16'h1);
        chk("t6_nmi_trap0", 16'(map2), 16'h0);

        // Port E3 paging control
        io_write(16'h00E3, 8'hC5);
        chk("t3_map_conmem", 16'(map2), 16'h1);
        chk("t3_ram_conmem", 16'(ram1), 16'h0);
        chk("t3_page5", 16'(page1), 16'h5);
        io_write(16'h00E3, 8'h00);
        chk("t3_ram_sticky", 16'(ram1), 16'h1);
        chk("t3_page0", 16'(page1), 16'h0);
        chk("t3_conmem_off", 16'(map2), 16'h0);
        io_write(16'h12E3, 8'h03);
        chk("t3_hi_addr", 16'(page1), 16'h3);
        io_write(16'h00E5, 8'h0F);
        chk("t3_other_port", 16'(page1), 16'h3);

        // SPI byte A5 in loopback
        io_write(16'h00E7, 8'h00);
        chk("t4_cs_low", 16'(cs1), 16'h0);
        exp_byte = 8'hA5;
        di = 8'hA5; a = 16'h00EB; iorq = 1'b0; wr = 1'b0;
        step();
        iorq = 1'b1; wr = 1'b1;
        chk("t4_first_mosi", 16'(mo1), 16'(exp_byte[7]));
        chk("t4_ck_idle", 16'(ck1), 16'h0);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k <= 16) chk($sformatf("t4_ck_%0d", k), 16'(ck1), 16'(k % 2));
            if (k <= 16 && (k % 2) == 1)
                chk($sformatf("t4_mosi_%0d", k), 16'(mo1), 16'(exp_byte[7 - (k - 1) / 2]));
            if (k == 8)  chk("t4_do_busy", 16'(do1), 16'h00FF);
            if (k == 15) chk("t4_do_before_end", 16'(do1), 16'h00FF);
            if (k == 16) chk("t4_do_end", 16'(do1), 16'h00A5);
            if (k == 16) chk("t4_mosi_idle", 16'(mo1), 16'h1);
            if (k == 31) chk("t4_div2_before_end", 16'(do2), 16'h00FF);
            if (k == 32) chk("t4_div2_end", 16'(do2), 16'h00A5);
        end

        // IN EB returns the byte and starts an FF transfer
        a = 16'h00EB; iorq = 1'b0; rd = 1'b0;
        #1;
        chk("t4_ioe", 16'(ioe1), 16'h1);
        chk("t4_in_do", 16'(do1), 16'h00A5);
        step();
        iorq = 1'b1; rd = 1'b1;
        #1;
        chk("t4_ioe_off", 16'(ioe1), 16'h0);
        step();
        chk("t4_in_starts", 16'(ck1), 16'h1);
        chk("t4_in_div2_wait", 16'(ck2), 16'h0);
        repeat (40) step();
        chk("t4_in_rx", 16'(do1), 16'h00FF);
        chk("t4_in_rx_div2", 16'(do2), 16'h00FF);

        // Start while busy is ignored; E7 write while busy takes effect
        io_write(16'h00EB, 8'h3C);
        io_write(16'h00EB, 8'hFF);
        io_write(16'h00E7, 8'h01);
        chk("t5_cs_busy", 16'(cs1), 16'h1);
        chk("t5_do_prev", 16'(do1), 16'h00FF);
        repeat (40) step();
        chk("t5_rx", 16'(do1), 16'h003C);
        chk("t5_rx_div2", 16'(do2), 16'h003C);

        // Reset at the 4th SCK pulse
        io_write(16'h00EB, 8'h5A);
        repeat (6) step();
        chk("t5_pulse4", 16'(ck1), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_ck", 16'(ck1), 16'h0);
        chk("t5_rst_do", 16'(do1), 16'h00FF);
        chk("t5_rst_mosi", 16'(mo1), 16'h1);
        chk("t5_rst_do_div2", 16'(do2), 16'h00FF);
        repeat (20) step();
        chk("t5_rst_stays_idle", 16'(ck1), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
